// File: rtl/nibble_serial_add16_pkg.sv
// nibble_serial_add16_pkg -- shared FSM state type and slice/index sizing for the nibble-serial adder.
// Rev 1.0
`default_nettype none

package nibble_serial_add16_pkg;

   localparam int NIB_W        = 4;
   localparam int NIBBLES_DFLT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The index register needs at least one bit even for a single-nibble build.
   function automatic int idx_width(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

   localparam int IDX_W_DFLT = idx_width(NIBBLES_DFLT);

endpackage

`default_nettype wire

// File: rtl/nibble_add4.sv
// nibble_add4 -- 4-bit ripple slice adder exposing the carry into bit 3 for overflow detection.
// Rev 1.0
`default_nettype none

module nibble_add4
   import nibble_serial_add16_pkg::*;
(
   input  logic [NIB_W-1:0] x,
   input  logic [NIB_W-1:0] y,
   input  logic             ci,
   output logic [NIB_W-1:0] s,
   output logic             co,
   output logic             c3
);

   logic [3:0] low;
   logic [1:0] top;

   // Split at bit 3 so the carry into the MSB of the slice is directly visible.
   assign low = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, ci};
   assign c3  = low[3];
   assign top = {1'b0, x[3]} + {1'b0, y[3]} + {1'b0, c3};
   assign s   = {top[0], low[2:0]};
   assign co  = top[1];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_add16.sv
// nibble_serial_add16 -- adds two W-bit operands one nibble per cycle through a single shared slice adder.
// Rev 1.0
`default_nettype none

module nibble_serial_add16
   import nibble_serial_add16_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                     clk1,
   input  logic                     rst1,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NIB_W*NIBBLES-1:0] a,
   input  logic [NIB_W*NIBBLES-1:0] b,
   input  logic                     cin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NIB_W*NIBBLES-1:0] sum,
   output logic                     cout,
   output logic                     ovf,
   output logic                     busy
);

   localparam int             W        = NIB_W * NIBBLES;
   localparam int             IW       = idx_width(NIBBLES);
   localparam logic [IW-1:0]  LAST_IDX = IW'(NIBBLES - 1);

   state_t          state;
   logic [IW-1:0]   idx;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic            carry;
   logic [W-1:0]    sum_q;
   logic            cout_q;
   logic            ovf_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic            busy_q;

   logic [NIB_W-1:0] nib_x;
   logic [NIB_W-1:0] nib_y;
   logic [NIB_W-1:0] add_s;
   logic             add_co;
   logic             add_c3;

   assign nib_x = op_a[NIB_W*idx +: NIB_W];
   assign nib_y = op_b[NIB_W*idx +: NIB_W];

   nibble_add4 u_add (
      .x  (nib_x),
      .y  (nib_y),
      .ci (carry),
      .s  (add_s),
      .co (add_co),
      .c3 (add_c3)
   );

   // Handshake flags are registered alongside the state so no input reaches an output combinationally.
   always_ff @(posedge clk1) begin
      if (rst1) begin
         state       <= IDLE;
         idx         <= '0;
         op_a        <= '0;
         op_b        <= '0;
         carry       <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a       <= a;
                  op_b       <= b;
                  carry      <= cin;
                  idx        <= '0;
                  state      <= RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               sum_q[NIB_W*idx +: NIB_W] <= add_s;
               carry                     <= add_co;
               if (idx == LAST_IDX) begin
                  cout_q      <= add_co;
                  ovf_q       <= add_c3 ^ add_co;
                  idx         <= '0;
                  state       <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               // Return to IDLE only; the next accept waits for the following edge.
               if (out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               idx         <= '0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add16.sv
// tb_nibble_serial_add16 -- directed self-checking bench for the nibble-serial adder.
// Rev 1.0
`default_nettype none

module tb_nibble_serial_add16;

   logic        clk1;
   logic        rst1;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic        busy;

   int tests;
   int fails;

   nibble_serial_add16 #(.NIBBLES(4)) dut (
      .clk1      (clk1),
      .rst1      (rst1),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   // Issue one operation, check latency and result, then release it and check retention.
   task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tc, input logic [15:0] es, input logic ec, input logic eo);
      int n;
      a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0; a = ~ta; b = 16'h5A5A; cin = ~tc;
      chk({tag, "_busy"}, {30'd0, busy, in_ready}, 32'd2);
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'd4);
      chk({tag, "_sum"}, {15'd0, cout, sum}, {15'd0, ec, es});
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_release"}, {29'd0, in_ready, out_valid, busy}, 32'd4);
      chk({tag, "_retain"}, {14'd0, ovf, cout, sum}, {14'd0, eo, ec, es});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] sa [10];
      logic [15:0] sb [10];
      logic        sc [10];
      logic [17:0] expq [$];
      logic [16:0] full;
      logic [17:0] e;
      int          issued;
      int          got;
      int          cyc;
      int          last_acc;
      bit          seen;
      logic [17:0] hold;

      tests = 0; fails = 0;
      rst1 = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      a = 16'hABCD; b = 16'h1111; cin = 1'b1;

      // Reset with in_valid high must not accept.
      repeat (3) step();
      chk("reset_flags", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'h8);
      chk("reset_result", {14'd0, ovf, cout, sum}, 32'd0);
      rst1 = 1'b0; in_valid = 1'b0;
      step();
      chk("post_reset_idle", {30'd0, in_ready, busy}, 32'd2);

      run_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_op("ripple",   16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
      run_op("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("ovf_neg",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      run_op("mixed",    16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b1, 1'b0);

      // DONE hold with out_ready low while inputs churn.
      a = 16'h0F0F; b = 16'h1010; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      chk("hold_enter", 32'(out_valid), 32'd1);
      hold = 18'({1'b0, 1'b0, 16'h1F1F});
      for (int i = 0; i < 5; i++) begin
         a = 16'(i * 16'h1357); b = ~a; in_valid = i[0];
         step();
         chk("hold_stable", {12'd0, in_ready, out_valid, ovf, cout, sum}, {12'd0, 2'b01, hold});
      end
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      // in_valid stayed high across the release edge; it must not be taken there.
      chk("hold_release", {29'd0, in_ready, out_valid, busy}, 32'd4);
      in_valid = 1'b0; out_ready = 1'b0;
      step();
      chk("hold_no_accept", 32'(busy), 32'd0);

      // Reset after the second RUN cycle discards the partial result.
      a = 16'h4321; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (2) step();
      rst1 = 1'b1;
      step();
      rst1 = 1'b0;
      chk("midrun_reset_flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
      chk("midrun_reset_result", {14'd0, ovf, cout, sum}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         seen = seen | out_valid;
      end
      chk("midrun_no_out_valid", 32'(seen), 32'd0);
      run_op("after_reset", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

      // Back-to-back stream against a reference model.
      for (int i = 0; i < 10; i++) begin
         sa[i] = 16'($urandom);
         sb[i] = 16'($urandom);
         sc[i] = 1'($urandom);
      end
      sa[0] = 16'h7FFF; sb[0] = 16'h0001; sc[0] = 1'b0;
      issued = 0; got = 0; cyc = 0; last_acc = -1;
      in_valid = 1'b1; out_ready = 1'b1;
      while (got < 10 && cyc < 200) begin
         if (out_valid) begin
            e = (expq.size() > 0) ? expq.pop_front() : 18'h3FFFF;
            chk("stream_result", {14'd0, ovf, cout, sum}, {14'd0, e});
            got++;
         end
         if (in_ready && issued < 10) begin
            a = sa[issued]; b = sb[issued]; cin = sc[issued];
            full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            e = {(a[15] == b[15]) && (full[15] != a[15]), full};
            expq.push_back(e);
            if (last_acc >= 0) chk("stream_spacing", 32'(cyc - last_acc), 32'd6);
            last_acc = cyc;
            issued++;
         end else if (issued >= 10) begin
            in_valid = 1'b0;
         end
         step();
         cyc++;
      end
      chk("stream_count", 32'(got), 32'd10);
      in_valid = 1'b0; out_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/nibble_serial_add16.md
NIBBLE_SERIAL_ADD16 -- requirements
Module: nibble_serial_add16

Interface
REQ-001 Parameter: NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 Port: clk1  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst1  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operand pair valid.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  W  operand A, unsigned or two's complement.
REQ-007 Port: b  input  W  operand B.
REQ-008 Port: cin  input  1  carry into nibble 0.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: sum  output  W  A+B+cin modulo 2^W.
REQ-012 Port: cout  output  1  carry out of the top nibble.
REQ-013 Port: ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).
REQ-014 Port: busy  output  1  high in RUN and DONE.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; encoding is internal.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept: IDLE with in_valid=1 SHALL latch a, b, cin into operand/carry registers, clear the nibble index to 0 and enter RUN.
REQ-018 RUN: each cycle SHALL add nibble[idx] of A and B plus the carry register through one 4-bit adder, write the 4-bit result into sum nibble[idx], update the carry register, and increment idx.
REQ-019 RUN SHALL exit to DONE on the edge that processes idx = NIBBLES-1; out_valid SHALL rise exactly NIBBLES edges after the accepting edge.
REQ-020 Exactly one 4-bit add SHALL occur per RUN cycle; idx SHALL never exceed NIBBLES-1.
REQ-021 On the final nibble, ovf SHALL be captured as (carry into bit 3 of top nibble) XOR (carry out of top nibble); cout SHALL equal the final carry register.
REQ-022 DONE: sum, cout, ovf SHALL hold stable while out_ready=0 for any number of cycles.
REQ-023 DONE with out_ready=1 SHALL return to IDLE on that edge; in_ready SHALL be 0 during that cycle (no bypass), so the next accept occurs no earlier than the following edge.
REQ-024 Sustained throughput with in_valid and out_ready held high SHALL be one result per NIBBLES+2 cycles.
REQ-025 Changes on a, b, cin, in_valid outside the accepting cycle SHALL have no effect on the current operation.
REQ-026 sum, cout, ovf SHALL retain the last completed result after leaving DONE until the next operation overwrites them.

Reset
REQ-027 rst1=1 at a rising edge SHALL force IDLE, idx=0, carry register=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1 on the next cycle.
REQ-028 Reset SHALL take priority over every transition, including mid-RUN and DONE; a partial result SHALL be discarded with no out_valid.
REQ-029 An in_valid asserted during the reset cycle SHALL NOT be accepted.

Structure
REQ-030 A shared package SHALL hold the FSM state type, the nibble width constant (4) and the index width derived from NIBBLES.
REQ-031 The 4-bit slice adder SHALL be one sub-module, nibble_add4 (inputs x[3:0], y[3:0], ci; outputs s[3:0], co, c3 = carry into bit 3), instantiated exactly once and reused every RUN cycle.
REQ-032 The block SHALL contain no combinational path from in_valid or out_ready to any output.

Verification
REQ-033 a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, cout=0, ovf=0, out_valid exactly 4 edges after accept.
REQ-034 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0 (full carry ripple across all nibbles).
REQ-035 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE while toggling a/b/in_valid -> sum/cout/ovf stable, in_ready=0, no second accept; release -> IDLE next cycle.
REQ-037 Assert rst1 for one cycle after the second RUN cycle -> IDLE, outputs at reset values, out_valid never asserted; next operation 0x1234+0x1111 -> 0x2345.
REQ-038 Back-to-back stream of 10 random operand pairs, in_valid and out_ready held high -> results match reference model, consecutive accepts exactly 6 cycles apart.
